// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a start/busy/done handshake.
// Shift-by-N and multiply run one iteration per clock; all other ops complete at the accepting edge.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sc_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             zero,
  output logic             pari,
  output logic             illegal
);
  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL1 = 4'd5;
  localparam logic [3:0] OP_SHR1 = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHLN = 4'd8;
  localparam logic [3:0] OP_SHRN = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   mcand;

  logic [WIDTH:0]     add_sum, sub_sum;
  logic [LW-1:0]      shamt;
  logic [WIDTH-1:0]   c_res;
  logic               c_sc, c_ill, c_multi;
  logic [CW-1:0]      c_k;

  assign add_sum = {1'b0, inA} + {1'b0, inB}  + {{WIDTH{1'b0}}, sc_i};
  assign sub_sum = {1'b0, inA} + {1'b0, ~inB} + {{WIDTH{1'b0}}, sc_i};
  assign shamt   = inB[LW-1:0];

  // Decode at the accepting edge: single-cycle result, or iteration count for multi-cycle ops
  always_comb begin
    c_res   = '0;
    c_sc    = 1'b0;
    c_ill   = 1'b0;
    c_multi = 1'b0;
    c_k     = '0;
    case (alu_cmd)
      OP_ADD:  {c_sc, c_res} = add_sum;
      OP_SUB:  {c_sc, c_res} = sub_sum;
      OP_AND:  c_res = inA & inB;
      OP_OR:   c_res = inA | inB;
      OP_XOR:  c_res = inA ^ inB;
      OP_SHL1: begin c_res = {inA[WIDTH-2:0], sc_i}; c_sc = inA[WIDTH-1]; end
      OP_SHR1: begin c_res = {sc_i, inA[WIDTH-1:1]}; c_sc = inA[0]; end
      OP_NOT:  c_res = ~inA;
      OP_SHLN, OP_SHRN: begin
        if (shamt == '0) c_res = inA;
        else begin
          c_multi = 1'b1;
          c_k     = {1'b0, shamt};
        end
      end
      OP_MUL: begin
        if (MUL_EN) begin
          c_multi = 1'b1;
          c_k     = CW'(WIDTH);
        end else c_ill = 1'b1;
      end
      default: c_ill = 1'b1;
    endcase
  end

  // One iteration; the multiplier keeps {partial product, remaining multiplier bits} in work
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] it_next;
  logic [WIDTH-1:0]   it_res;
  logic               it_sc;

  assign mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mcand} : '0);

  always_comb begin
    it_next = {mul_sum, work[WIDTH-1:1]};
    it_res  = it_next[WIDTH-1:0];
    it_sc   = |it_next[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_SHLN: begin
        it_next = {{WIDTH{1'b0}}, work[WIDTH-2:0], 1'b0};
        it_res  = it_next[WIDTH-1:0];
        it_sc   = work[WIDTH-1];
      end
      OP_SHRN: begin
        it_next = {{WIDTH{1'b0}}, 1'b0, work[WIDTH-1:1]};
        it_res  = it_next[WIDTH-1:0];
        it_sc   = work[0];
      end
      default: ;
    endcase
  end

  logic             accept, run_last, fin_en, fin_sc, fin_ill;
  logic [WIDTH-1:0] fin_res;

  assign accept   = (state == IDLE) && start;
  assign run_last = (state == RUN) && (cnt == CW'(1));
  assign fin_en   = (accept && !c_multi) || run_last;
  assign fin_res  = (state == RUN) ? it_res : c_res;
  assign fin_sc   = (state == RUN) ? it_sc  : c_sc;
  assign fin_ill  = (state == RUN) ? 1'b0   : c_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rslt    <= '0;
      sc_o    <= 1'b0;
      zero    <= 1'b1;
      pari    <= 1'b0;
      illegal <= 1'b0;
      op_q    <= '0;
      cnt     <= '0;
      work    <= '0;
      mcand   <= '0;
    end else begin
      done <= fin_en;
      if (fin_en) begin
        rslt    <= fin_res;
        sc_o    <= fin_sc;
        zero    <= (fin_res == '0);
        pari    <= ^fin_res;
        illegal <= fin_ill;
      end
      case (state)
        IDLE: begin
          if (accept && c_multi) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= alu_cmd;
            cnt   <= c_k;
            mcand <= inA;
            work  <= (alu_cmd == OP_MUL) ? {{WIDTH{1'b0}}, inB} : {{WIDTH{1'b0}}, inA};
          end
        end
        RUN: begin
          work <= it_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): scoreboard of model results, latency and handshake checks,
// plus a second instance with the multiplier disabled.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n, start, sc_in;
  logic [3:0] alu_cmd;
  logic [7:0] op_a, op_b;

  logic       busy, done, sc_o, zero, pari, illegal;
  logic [7:0] rslt;
  logic       busy0, done0, sc_o0, zero0, pari0, illegal0;
  logic [7:0] rslt0;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_cmd(alu_cmd), .inA(op_a), .inB(op_b),
    .sc_i(sc_in), .busy(busy), .done(done), .rslt(rslt), .sc_o(sc_o), .zero(zero),
    .pari(pari), .illegal(illegal));

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_cmd(alu_cmd), .inA(op_a), .inB(op_b),
    .sc_i(sc_in), .busy(busy0), .done(done0), .rslt(rslt0), .sc_o(sc_o0), .zero(zero0),
    .pari(pari0), .illegal(illegal0));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       sc, zero, pari, ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t last, e;
  int   n_chk = 0, n_fail = 0;

  function automatic exp_t model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                 input logic sci, input bit mul_en);
    exp_t        r;
    logic [8:0]  s;
    logic [15:0] p;
    int          k;
    r = '0;
    k = int'(b[2:0]);
    case (cmd)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, sci};  {r.sc, r.res} = s; end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + {8'd0, sci}; {r.sc, r.res} = s; end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: begin r.res = {a[6:0], sci}; r.sc = a[7]; end
      4'd6: begin r.res = {sci, a[7:1]}; r.sc = a[0]; end
      4'd7: r.res = ~a;
      4'd8: begin r.res = a << k; r.sc = (k == 0) ? 1'b0 : a[8-k]; end
      4'd9: begin r.res = a >> k; r.sc = (k == 0) ? 1'b0 : a[k-1]; end
      4'd10: begin
        if (mul_en) begin
          p = {8'd0, a} * {8'd0, b};
          r.res = p[7:0];
          r.sc  = |p[15:8];
        end else r.ill = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.res == 8'd0);
    r.pari = ^r.res;
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] cmd, input logic [7:0] b);
    if ((cmd == 4'd8 || cmd == 4'd9) && b[2:0] != 3'd0) return int'(b[2:0]) + 1;
    if (cmd == 4'd10) return 9;
    return 1;
  endfunction

  // Drives one start pulse; returns 1 ns after the accepting edge with operands scrambled
  task automatic issue(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b, input logic sci);
    @(negedge clk);
    start = 1'b1; alu_cmd = cmd; op_a = a; op_b = b; sc_in = sci;
    @(posedge clk); #1;
    start = 1'b0; alu_cmd = 4'($urandom); op_a = 8'($urandom); op_b = 8'($urandom); sc_in = 1'($urandom);
  endtask

  // Edges since acceptance when done is seen (n0 = edges already elapsed), -1 on timeout
  task automatic wait_done(input int n0, input int max, output int lat);
    int n = n0;
    while (!done && n < max) begin @(posedge clk); #1; n++; end
    lat = done ? n : -1;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({rslt, sc_o, zero, pari, illegal, busy, done} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rslt=%h sc=%b z=%b p=%b ill=%b busy=%b done=%b, want 00 0 1 0 0 0 0",
               rslt, sc_o, zero, pari, illegal, busy, done);
    end
    last = model(4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_single;
    logic [3:0] cmds[4] = '{4'd0, 4'd1, 4'd7, 4'd5};
    logic [7:0] as[4]   = '{8'hF0, 8'h05, 8'h5A, 8'h80};
    logic [7:0] bs[4]   = '{8'h20, 8'h07, 8'h00, 8'h00};
    logic       cs[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_t       fix[4]  = '{{8'h11, 1'b1, 1'b0, 1'b0, 1'b0}, {8'hFE, 1'b0, 1'b0, 1'b1, 1'b0},
                            {8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}, {8'h01, 1'b1, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(cmds[i], as[i], bs[i], cs[i], 1'b1));
      issue(cmds[i], as[i], bs[i], cs[i]);
      n_chk++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_handshake[%0d]: got done=%b busy=%b, want 1 0", i, done, busy);
      end
      e = exp_q.pop_front();
      last = e;
      n_chk++;
      if ({rslt, sc_o, zero, pari, illegal} !== e) begin
        n_fail++;
        $display("FAIL single_sb[%0d]: got %h/%b%b%b%b, want %h/%b%b%b%b", i, rslt, sc_o, zero, pari,
                 illegal, e.res, e.sc, e.zero, e.pari, e.ill);
      end
      n_chk++;
      if ({rslt, sc_o, zero, pari, illegal} !== fix[i]) begin
        n_fail++;
        $display("FAIL single_fixed[%0d]: got %h/%b, want %h/%b", i, rslt, sc_o, fix[i].res, fix[i].sc);
      end
    end
  endtask

  task automatic test_shln;
    int lat;
    exp_q.push_back(model(4'd8, 8'hB1, 8'h03, 1'b0, 1'b1));
    issue(4'd8, 8'hB1, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0 || rslt !== last.res) begin
        n_fail++;
        $display("FAIL shln_hold[E%0d]: got busy=%b done=%b rslt=%h, want 1 0 %h", i, busy, done, rslt, last.res);
      end
      @(posedge clk); #1;
    end
    wait_done(4, 4, lat);
    n_chk++;
    if (lat !== 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL shln_latency: got %0d busy=%b, want 4 0", lat, busy);
    end
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if ({rslt, sc_o, zero, pari, illegal} !== e || rslt !== 8'h88 || sc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL shln_result: got %h/%b, want 88/1", rslt, sc_o);
    end
    exp_q.push_back(model(4'd8, 8'hB1, 8'h00, 1'b1, 1'b1));
    issue(4'd8, 8'hB1, 8'h00, 1'b1);
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || {rslt, sc_o, zero, pari, illegal} !== e || rslt !== 8'hB1) begin
      n_fail++;
      $display("FAIL shln_zero_count: got done=%b busy=%b %h/%b, want 1 0 b1/0", done, busy, rslt, sc_o);
    end
  endtask

  task automatic test_mul_back_to_back;
    int lat;
    exp_q.push_back(model(4'd10, 8'h13, 8'h0E, 1'b0, 1'b1));
    issue(4'd10, 8'h13, 8'h0E, 1'b0);
    // ADD during busy must be dropped
    @(negedge clk);
    start = 1'b1; alu_cmd = 4'd0; op_a = 8'h01; op_b = 8'h01; sc_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ignore_start: got done=%b busy=%b, want 0 1", done, busy);
    end
    wait_done(2, 20, lat);
    n_chk++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d, want 9", lat);
    end
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if ({rslt, sc_o, zero, pari, illegal} !== e || rslt !== 8'h0A || sc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_result: got %h/%b, want 0a/1", rslt, sc_o);
    end
    exp_q.push_back(model(4'd3, 8'h30, 8'h03, 1'b0, 1'b1));
    issue(4'd3, 8'h30, 8'h03, 1'b0);
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if (done !== 1'b1 || {rslt, sc_o, zero, pari, illegal} !== e) begin
      n_fail++;
      $display("FAIL back_to_back: got done=%b rslt=%h, want 1 %h", done, rslt, e.res);
    end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back(model(4'd10, 8'hFF, 8'hFF, 1'b0, 1'b1));
    issue(4'd10, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_chk++;
    if ({busy, done, rslt, zero, illegal} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%b done=%b rslt=%h zero=%b, want 0 0 00 1", busy, done, rslt, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(4'd0, 8'h01, 8'h01, 1'b0, 1'b1));
    issue(4'd0, 8'h01, 8'h01, 1'b0);
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if (done !== 1'b1 || {rslt, sc_o, zero, pari, illegal} !== e || rslt !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_then_add: got done=%b rslt=%h, want 1 02", done, rslt);
    end
  endtask

  task automatic test_reserved;
    int lat;
    exp_q.push_back(model(4'd12, 8'h55, 8'hAA, 1'b1, 1'b1));
    issue(4'd12, 8'h55, 8'hAA, 1'b1);
    e = exp_q.pop_front();
    n_chk++;
    if (done !== 1'b1 || {rslt, sc_o, zero, pari, illegal} !== e || illegal !== 1'b1 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved_12: got done=%b rslt=%h ill=%b zero=%b, want 1 00 1 1", done, rslt, illegal, zero);
    end
    exp_q.push_back(model(4'd0, 8'h10, 8'h20, 1'b0, 1'b1));
    issue(4'd0, 8'h10, 8'h20, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if (illegal !== 1'b0 || {rslt, sc_o, zero, pari, illegal} !== e) begin
      n_fail++;
      $display("FAIL reserved_clear: got ill=%b rslt=%h, want 0 %h", illegal, rslt, e.res);
    end
    exp_q.push_back(model(4'd10, 8'h13, 8'h0E, 1'b0, 1'b1));
    issue(4'd10, 8'h13, 8'h0E, 1'b0);
    n_chk++;
    if ({done0, busy0, rslt0, sc_o0, zero0, illegal0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_disabled: got done=%b busy=%b rslt=%h sc=%b zero=%b ill=%b, want 1 0 00 0 1 1",
               done0, busy0, rslt0, sc_o0, zero0, illegal0);
    end
    wait_done(1, 20, lat);
    e = exp_q.pop_front();
    last = e;
    n_chk++;
    if (lat !== 9 || illegal !== 1'b0 || {rslt, sc_o, zero, pari, illegal} !== e) begin
      n_fail++;
      $display("FAIL mul_enabled_not_reserved: got lat=%0d ill=%b rslt=%h, want 9 0 %h", lat, illegal, rslt, e.res);
    end
  endtask

  task automatic test_random;
    int         lat;
    logic [3:0] c;
    logic [7:0] a, b;
    logic       s;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 11));
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      exp_q.push_back(model(c, a, b, s, 1'b1));
      issue(c, a, b, s);
      wait_done(1, 20, lat);
      e = exp_q.pop_front();
      n_chk++;
      if (lat !== lat_of(c, b) || {rslt, sc_o, zero, pari, illegal} !== e) begin
        n_fail++;
        $display("FAIL random[%0d] cmd=%0d a=%h b=%h sc=%b: got lat=%0d %h/%b%b%b%b, want lat=%0d %h/%b%b%b%b",
                 i, c, a, b, s, lat, rslt, sc_o, zero, pari, illegal, lat_of(c, b), e.res, e.sc, e.zero,
                 e.pari, e.ill);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_cmd = 4'd0; op_a = 8'd0; op_b = 8'd0; sc_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_shln;
    test_mul_back_to_back;
    test_reset_mid;
    test_reserved;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
